// File: rtl/spart_rx.sv
// SPART serial receiver: oversampled 8N1 deserialiser with a one-deep receive
// buffer and rda / framing-error / overrun status for the bus interface.
module spart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       brg_ready,
  input  logic       rxd,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       framing_error,
  output logic       overrun
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  logic [1:0]    state;
  logic [TW-1:0] tick;
  logic [2:0]    idx;
  logic          armed;
  logic [7:0]    shreg;
  logic          rx_s1;
  logic          rxs;
  logic          complete;

  // Stop-bit centre: the frame finishes on this very edge, no extra stage.
  assign complete = brg_ready && sample_en && (state == STOP) && (tick == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1         <= 1'b1;
      rxs           <= 1'b1;
      state         <= IDLE;
      tick          <= '0;
      idx           <= '0;
      armed         <= 1'b0;
      shreg         <= '0;
      rx_data       <= '0;
      rda           <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rxs   <= rx_s1;

      if (!brg_ready) begin
        state <= IDLE;
        tick  <= '0;
        idx   <= '0;
        armed <= 1'b0;
      end else if (sample_en) begin
        case (state)
          IDLE: begin
            // Line must be seen high before a falling edge can start a frame.
            if (rxs) begin
              armed <= 1'b1;
            end else if (armed) begin
              state <= START;
              tick  <= '0;
              armed <= 1'b0;
            end
          end
          START: begin
            if (tick == TICK_HALF) begin
              tick <= '0;
              if (!rxs) begin
                state <= DATA;
                idx   <= '0;
              end else begin
                state <= IDLE;
                armed <= 1'b1;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
          DATA: begin
            if (tick == TICK_LAST) begin
              tick  <= '0;
              shreg <= {rxs, shreg[7:1]};
              if (idx == IDX_LAST) begin
                state <= STOP;
              end else begin
                idx <= idx + 3'd1;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
          STOP: begin
            if (tick == TICK_LAST) begin
              tick  <= '0;
              state <= IDLE;
              armed <= rxs;
            end else begin
              tick <= tick + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // A completion coinciding with rd_en reloads the buffer instead of clearing it.
      if (complete) begin
        if (!rda || rd_en) begin
          rx_data       <= shreg >> (8 - DATA_BITS);
          rda           <= 1'b1;
          framing_error <= ~rxs;
          overrun       <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_en) begin
        rda           <= 1'b0;
        framing_error <= 1'b0;
        overrun       <= 1'b0;
      end
    end
  end

endmodule
